song_sequencer: RTL

- Playback-side counterpart of the song elapsed-time counter. Produces drum-note events from song memory and raises song_done.
- Walks a song ROM/BRAM of timestamped entries and waits each entry's delta time in ticks. Emits a one-cycle note event with a pad mask.
- Asserts song_done when it reads an end marker.
- Controlled by the central FSM through start_song and pause_song. song_done feeds the timing counter and the FSM; note events feed the scoring and graphics logic.

---
 rtl/song_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// Song playback sequencer: walks timestamped song entries, waits each delta in ticks, pulses note events.
// Optional SONG_LOOP_EN: end marker or address wrap restarts at entry 0 and pulses loop_pulse.
module song_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int TICK_DELAY = 269999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_song,
  input  logic              pause_song,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              note_valid,
  output logic [7:0]        note_pads,
  output logic              song_done,
  output logic              playing,
`ifdef SONG_LOOP_EN
  output logic              loop_pulse,
`endif
  output logic [2:0]        dbg_state_o
);

  localparam int PRE_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               note_valid_q;
  logic [7:0]         note_pads_q;
  logic               done_q;
  logic [7:0]         remaining_q;
  logic [PRE_W-1:0]   prescaler_q;
  logic [7:0]         pads_q;
  logic               loop_pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      note_valid_q <= 1'b0;
      note_pads_q  <= 8'h00;
      done_q       <= 1'b0;
      remaining_q  <= 8'h00;
      prescaler_q  <= '0;
      pads_q       <= 8'h00;
      loop_pulse_q <= 1'b0;
    end else if (start_song) begin
      state_q      <= S_ADDR;
      addr_q       <= '0;
      done_q       <= 1'b0;
      prescaler_q  <= '0;
      note_valid_q <= 1'b0;
      loop_pulse_q <= 1'b0;
    end else begin
      note_valid_q <= 1'b0;
      loop_pulse_q <= 1'b0;
      unique case (state_q)
        S_IDLE: state_q <= S_IDLE;
        // mem_addr is presented here; the BRAM returns the entry during LOAD.
        S_ADDR: state_q <= S_LOAD;
        S_LOAD: begin
          if (mem_data == 16'h0000) begin
`ifdef SONG_LOOP_EN
            state_q      <= S_ADDR;
            addr_q       <= '0;
            loop_pulse_q <= 1'b1;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            remaining_q <= mem_data[15:8];
            pads_q      <= mem_data[7:0];
            prescaler_q <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!pause_song) begin
            if (remaining_q == 8'h00) begin
              note_valid_q <= 1'b1;
              note_pads_q  <= pads_q;
              if (addr_q == {ADDR_W{1'b1}}) begin
`ifdef SONG_LOOP_EN
                state_q      <= S_ADDR;
                addr_q       <= '0;
                loop_pulse_q <= 1'b1;
`else
                state_q <= S_DONE;
                done_q  <= 1'b1;
`endif
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= S_ADDR;
              end
            end else if (prescaler_q == PRE_W'(TICK_DELAY)) begin
              prescaler_q <= '0;
              remaining_q <= remaining_q - 8'd1;
            end else begin
              prescaler_q <= prescaler_q + 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign note_valid  = note_valid_q;
  assign note_pads   = note_pads_q;
  assign song_done   = done_q;
  assign playing     = (state_q == S_ADDR) || (state_q == S_LOAD) || (state_q == S_WAIT);
  assign dbg_state_o = state_q;
`ifdef SONG_LOOP_EN
  assign loop_pulse  = loop_pulse_q;
`else
  logic unused_loop;
  assign unused_loop = loop_pulse_q;
`endif

endmodule
